// File: rtl/enemy_missile_ctl.sv
// Enemy missile controller: five missile slots launched on a fire timer and
// advanced downward on a move timer; IDLE slots park at (0,0).
module enemy_missile_ctl #(
  parameter int unsigned MOVE_PERIOD = 100000,
  parameter int unsigned FIRE_PERIOD = 3000000,
  parameter int unsigned STEP        = 4,
  parameter int unsigned Y_START     = 100,
  parameter int unsigned Y_LIMIT     = 768
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        enable,
  input  logic [10:0] shooter_x,
  input  logic        ship_down,
  output logic [10:0] en_x_missile1,
  output logic [10:0] en_x_missile2,
  output logic [10:0] en_x_missile3,
  output logic [10:0] en_x_missile4,
  output logic [10:0] en_x_missile5,
  output logic [10:0] en_y_missile1,
  output logic [10:0] en_y_missile2,
  output logic [10:0] en_y_missile3,
  output logic [10:0] en_y_missile4,
  output logic [10:0] en_y_missile5,
  output logic [4:0]  active,
  output logic        launch
);

  localparam int unsigned N_SLOTS = 5;
  localparam int unsigned XW      = 11;
  localparam int unsigned YW      = 11;
  localparam int unsigned SW      = 12;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned MOVE_W  = 20;
  localparam int unsigned FIRE_W  = 24;

  typedef enum logic {S_IDLE, S_FLY} slot_state_t;

  slot_state_t       r_state [N_SLOTS];
  logic [XW-1:0]     r_x     [N_SLOTS];
  logic [YW-1:0]     r_y     [N_SLOTS];
  logic [MOVE_W-1:0] r_move_cnt;
  logic [FIRE_W-1:0] r_fire_cnt;
  logic              r_launch;

  logic              w_move_tc;
  logic              w_fire_tc;
  logic              w_free_found;
  logic [IDX_W-1:0]  w_free_idx;
  logic [SW-1:0]     w_sum   [N_SLOTS];
  logic [N_SLOTS-1:0] w_retire;

  assign w_move_tc = enable && (r_move_cnt == MOVE_W'(MOVE_PERIOD - 1));
  assign w_fire_tc = enable && (r_fire_cnt == FIRE_W'(FIRE_PERIOD - 1));

  // Lowest-numbered IDLE slot, judged on the state before this cycle's retirements
  always_comb begin
    w_free_found = 1'b0;
    w_free_idx   = '0;
    for (int k = N_SLOTS - 1; k >= 0; k--) begin
      if (r_state[k] == S_IDLE) begin
        w_free_found = 1'b1;
        w_free_idx   = IDX_W'(k);
      end
    end
  end

  always_comb begin
    for (int k = 0; k < N_SLOTS; k++) begin
      w_sum[k]    = {1'b0, r_y[k]} + SW'(STEP);
      w_retire[k] = 32'(w_sum[k]) >= Y_LIMIT;
    end
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      r_move_cnt <= '0;
      r_fire_cnt <= '0;
      r_launch   <= 1'b0;
      for (int k = 0; k < N_SLOTS; k++) begin
        r_state[k] <= S_IDLE;
        r_x[k]     <= '0;
        r_y[k]     <= '0;
      end
    end else if (ship_down) begin
      r_move_cnt <= '0;
      r_fire_cnt <= '0;
      r_launch   <= 1'b0;
      for (int k = 0; k < N_SLOTS; k++) begin
        r_state[k] <= S_IDLE;
        r_x[k]     <= '0;
        r_y[k]     <= '0;
      end
    end else if (!enable) begin
      r_launch <= 1'b0;
    end else begin
      r_move_cnt <= w_move_tc ? '0 : r_move_cnt + MOVE_W'(1);
      r_fire_cnt <= w_fire_tc ? '0 : r_fire_cnt + FIRE_W'(1);
      r_launch   <= w_fire_tc && w_free_found;
      for (int k = 0; k < N_SLOTS; k++) begin
        if (w_fire_tc && w_free_found && (w_free_idx == IDX_W'(k))) begin
          r_state[k] <= S_FLY;
          r_x[k]     <= shooter_x;
          r_y[k]     <= YW'(Y_START);
        end else if (w_move_tc && (r_state[k] == S_FLY)) begin
          if (w_retire[k]) begin
            r_state[k] <= S_IDLE;
            r_x[k]     <= '0;
            r_y[k]     <= '0;
          end else begin
            r_y[k] <= w_sum[k][YW-1:0];
          end
        end
      end
    end
  end

  assign en_x_missile1 = r_x[0];
  assign en_x_missile2 = r_x[1];
  assign en_x_missile3 = r_x[2];
  assign en_x_missile4 = r_x[3];
  assign en_x_missile5 = r_x[4];
  assign en_y_missile1 = r_y[0];
  assign en_y_missile2 = r_y[1];
  assign en_y_missile3 = r_y[2];
  assign en_y_missile4 = r_y[3];
  assign en_y_missile5 = r_y[4];
  assign launch        = r_launch;

  for (genvar g = 0; g < N_SLOTS; g++) begin : g_active
    assign active[g] = (r_state[g] == S_FLY);
  end

endmodule

// File: tb/tb_enemy_missile_ctl.sv
// Directed bench: one instance with a short screen (Y_LIMIT=120), one with a
// tall screen (Y_LIMIT=2000) so all five slots can fill.
module tb_enemy_missile_ctl;

  logic        pclk;
  logic        rst;
  logic        enable;
  logic [10:0] shooter_x;
  logic        ship_down;

  logic [10:0] a_x1, a_x2, a_x3, a_x4, a_x5, a_y1, a_y2, a_y3, a_y4, a_y5;
  logic [4:0]  a_act;
  logic        a_launch;
  logic [10:0] b_x1, b_x2, b_x3, b_x4, b_x5, b_y1, b_y2, b_y3, b_y4, b_y5;
  logic [4:0]  b_act;
  logic        b_launch;

  int n_chk  = 0;
  int n_pass = 0;

  enemy_missile_ctl #(
    .MOVE_PERIOD(4), .FIRE_PERIOD(10), .STEP(4), .Y_START(100), .Y_LIMIT(120)
  ) dut_a (
    .pclk(pclk), .rst(rst), .enable(enable), .shooter_x(shooter_x), .ship_down(ship_down),
    .en_x_missile1(a_x1), .en_x_missile2(a_x2), .en_x_missile3(a_x3),
    .en_x_missile4(a_x4), .en_x_missile5(a_x5),
    .en_y_missile1(a_y1), .en_y_missile2(a_y2), .en_y_missile3(a_y3),
    .en_y_missile4(a_y4), .en_y_missile5(a_y5),
    .active(a_act), .launch(a_launch)
  );

  enemy_missile_ctl #(
    .MOVE_PERIOD(4), .FIRE_PERIOD(10), .STEP(4), .Y_START(100), .Y_LIMIT(2000)
  ) dut_b (
    .pclk(pclk), .rst(rst), .enable(enable), .shooter_x(shooter_x), .ship_down(ship_down),
    .en_x_missile1(b_x1), .en_x_missile2(b_x2), .en_x_missile3(b_x3),
    .en_x_missile4(b_x4), .en_x_missile5(b_x5),
    .en_y_missile1(b_y1), .en_y_missile2(b_y2), .en_y_missile3(b_y3),
    .en_y_missile4(b_y4), .en_y_missile5(b_y5),
    .active(b_act), .launch(b_launch)
  );

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    else n_pass++;
  endtask

  // Advance n rising edges, then settle 1 ns past the last edge
  task automatic step(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  initial begin
    rst       = 1'b0;
    enable    = 1'b0;
    ship_down = 1'b0;
    shooter_x = 11'd300;
    #2;
    check("rst_x1", 32'(a_x1), 0);
    check("rst_y1", 32'(a_y1), 0);
    check("rst_act", 32'(a_act), 0);
    check("rst_launch", 32'(a_launch), 0);

    @(posedge pclk); #1;
    rst    = 1'b1;
    enable = 1'b1;

    step(9);
    check("pre_launch", 32'(a_launch), 0);
    check("pre_act", 32'(a_act), 0);
    step(1);
    check("l1_pulse", 32'(a_launch), 1);
    check("l1_x1", 32'(a_x1), 300);
    check("l1_y1", 32'(a_y1), 100);
    check("l1_act", 32'(a_act), 5'b00001);
    check("l1_act_b", 32'(b_act), 5'b00001);
    shooter_x = 11'd500;
    step(1);
    check("l1_pulse_end", 32'(a_launch), 0);
    check("l1_y1_hold", 32'(a_y1), 100);
    step(1);
    check("mv_104", 32'(a_y1), 104);
    step(4);
    check("mv_108", 32'(a_y1), 108);
    step(4);
    check("mv_112", 32'(a_y1), 112);
    check("x1_const", 32'(a_x1), 300);
    check("l2_act", 32'(a_act), 5'b00011);
    check("l2_x2", 32'(a_x2), 500);
    check("l2_y2_unmoved", 32'(a_y2), 100);
    check("l2_pulse", 32'(a_launch), 1);
    step(4);
    check("mv_116", 32'(a_y1), 116);
    check("y2_104", 32'(a_y2), 104);
    step(4);
    check("retire_x1", 32'(a_x1), 0);
    check("retire_y1", 32'(a_y1), 0);
    check("retire_act", 32'(a_act), 5'b00010);
    check("y2_108", 32'(a_y2), 108);
    step(2);
    check("reuse_act", 32'(a_act), 5'b00011);
    check("reuse_x1", 32'(a_x1), 500);
    check("reuse_y1", 32'(a_y1), 100);
    check("reuse_pulse", 32'(a_launch), 1);
    check("b_act_3", 32'(b_act), 5'b00111);
    shooter_x = 11'd700;

    step(20);
    check("full_act", 32'(b_act), 5'h1F);
    check("full_x5", 32'(b_x5), 700);
    check("full_y5", 32'(b_y5), 100);
    step(10);
    check("sixth_no_pulse", 32'(b_launch), 0);
    check("sixth_act", 32'(b_act), 5'h1F);
    check("sixth_y5", 32'(b_y5), 112);
    check("sixth_x1", 32'(b_x1), 300);

    step(9);
    ship_down = 1'b1;
    step(1);
    ship_down = 1'b0;
    check("sd_act", 32'(b_act), 0);
    check("sd_launch", 32'(b_launch), 0);
    check("sd_x1", 32'(b_x1), 0);
    check("sd_y5", 32'(b_y5), 0);
    check("sd_act_a", 32'(a_act), 0);
    step(9);
    check("sd_wait_launch", 32'(b_launch), 0);
    step(1);
    check("sd_relaunch", 32'(b_launch), 1);
    check("sd_relaunch_act", 32'(b_act), 5'b00001);
    check("sd_relaunch_x1", 32'(b_x1), 700);
    check("sd_relaunch_y1", 32'(b_y1), 100);

    step(2);
    check("pre_freeze_y1", 32'(b_y1), 104);
    enable = 1'b0;
    step(50);
    check("frz_y1", 32'(b_y1), 104);
    check("frz_act", 32'(b_act), 5'b00001);
    check("frz_launch", 32'(b_launch), 0);
    enable = 1'b1;
    step(3);
    check("resume_hold", 32'(b_y1), 104);
    step(1);
    check("resume_108", 32'(b_y1), 108);
    step(4);
    check("resume_launch", 32'(b_launch), 1);
    check("resume_act", 32'(b_act), 5'b00011);
    check("resume_y1", 32'(b_y1), 112);
    check("resume_y2", 32'(b_y2), 100);

    #3;
    rst = 1'b0;
    #1;
    check("arst_act", 32'(b_act), 0);
    check("arst_launch", 32'(b_launch), 0);
    check("arst_x1", 32'(b_x1), 0);
    check("arst_y1", 32'(b_y1), 0);
    check("arst_y2", 32'(b_y2), 0);
    #2;
    rst = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
